sdram_ctrl: RTL and testbench
=============================

Name: sdram_ctrl

Overview:
- Single-port controller that acts as the initiator for the on-package 2M x 32 SDRAM: 4 banks, 2048 rows, 256 columns.
- Runs power-up init, periodic auto-refresh, and single-word reads and writes with auto-precharge.
- Presents a simple req/ready/rvalid word interface to the SoC bus bridge.
- The top level merges `sd_dq_o`, `sd_dq_oe` and `sd_dq_i` into the `dq` inout of the SDRAM wrapper.

Parameters:
- INIT_WAIT, 20000: power-up wait in clk cycles before the first command (200 us at 100 MHz).
- REF_INTERVAL, 780: cycles between auto-refresh requests.
- T_RP, 2: precharge-to-command cycles.
- T_RC, 7: ACT-to-ACT and REF-to-command cycles.
- T_RCD, 2: ACT-to-READ/WRITE cycles.
- T_WR, 2: write recovery cycles before precharge.
- CL, 2: CAS latency. Must be 2 or 3 and matches the mode register.

Ports:
- clk  in  1  system clock; the SDRAM clock is in phase with it.
- rst  in  1  synchronous active-high reset.
- req  in  1  access request.
- we  in  1  1 = write, 0 = read.
- addr  in  21  word address: [20:19] bank, [18:8] row, [7:0] column.
- wdata  in  32  write data.
- wmask  in  4  byte enables, 1 = write the byte.
- ready  out  1  controller can accept a request this cycle.
- rvalid  out  1  one-cycle pulse; rdata is valid.
- rdata  out  32  read data.
- sd_cke  out  1  clock enable.
- sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n  out  1 each  command pins.
- sd_ba  out  2  bank address.
- sd_addr  out  11  row, column or mode address.
- sd_dm  out  4  data masks (dm3..dm0).
- sd_dq_o  out  32  write data to pins.
- sd_dq_oe  out  1  dq output enable.
- sd_dq_i  in  32  data from pins.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst` is synchronous and active-high.
  - All outputs are registered.
- Reset values:
  - sd_cke = 1.
  - Command NOP.
  - sd_ba = 0, sd_addr = 0, sd_dm = 4'hF.
  - sd_dq_oe = 0, sd_dq_o = 0.
  - ready = 0, rvalid = 0, rdata = 0.
  - State INIT_WAIT; all counters cleared.
- Reset during any operation aborts it, drops any pending rvalid, and restarts the full init sequence.
- Command encoding, {cs_n, ras_n, cas_n, we_n}:
  - NOP = 0111, ACT = 0011, READ = 0101, WRITE = 0100.
  - PRE = 0010 with A10 = 1 (precharge all).
  - REF = 0001.
  - MRS = 0000 with sd_addr = 11'h020 (BL1, sequential, CL = 2) or 11'h030 (CL = 3).
  - Any state not issuing a command drives NOP.
- Init sequence:
  - INIT_WAIT holds NOP for INIT_WAIT cycles.
  - INIT_PRE issues PRE, then waits T_RP.
  - INIT_REF1 issues REF, waits T_RC; INIT_REF2 issues REF, waits T_RC.
  - INIT_MRS issues MRS, waits 2 cycles, then goes to IDLE.
  - The refresh counter starts when IDLE is first entered.
- IDLE and request acceptance:
  - ready = 1 only in IDLE with ref_pending = 0.
  - A request is accepted on a cycle with req & ready. addr, we, wdata and wmask are latched that cycle; ready drops the next cycle.
  - req while ready = 0 is ignored. The requester holds req until it sees ready.
- Access sequence, cycle 0 = accept cycle:
  - ACT (bank, row) is driven in cycle 1.
  - READ or WRITE is driven in cycle 1+T_RCD, with sd_addr[7:0] = column, sd_addr[10] = 1 (auto-precharge), sd_addr[9:8] = 0.
- Write:
  - In the WRITE cycle only: sd_dq_o = wdata, sd_dq_oe = 1, sd_dm = ~wmask.
  - sd_dm = 4'hF in all other cycles.
  - After the WRITE, wait T_WR + T_RP, and at least T_RC after ACT, then return to IDLE.
  - No response pulse is generated for writes.
- Read:
  - sd_dq_i is registered into rdata on the clock edge CL+1 cycles after the READ cycle.
  - rvalid = 1 for exactly that one following cycle. With defaults, rvalid is in cycle 6 after accept.
  - Return to IDLE after max(CL+1, T_RP) cycles, and at least T_RC after ACT.
- Refresh:
  - A free-running counter sets the sticky flag ref_pending every REF_INTERVAL cycles, including during accesses.
  - In IDLE, ref_pending has priority over req: REF is issued, ref_pending clears, and the controller waits T_RC.
  - If req and the refresh tick arrive in the same cycle, refresh wins. ready is low that cycle, so the request is not accepted.
- A new request may not be accepted in the same cycle an access completes; IDLE must be entered first.

Test Plan:
- Init, with INIT_WAIT=100 and REF_INTERVAL=200 → 100 NOP cycles, PRE(A10=1), 2 REF spaced T_RC, MRS addr=11'h020; ready rises 2 cycles after MRS.
- Write addr=21'h1A_5F3C, wdata=32'hDEADBEEF, wmask=4'hF → ACT ba=3, row=11'h25F at cycle 1; WRITE col=8'h3C, A10=1, dq_oe=1, dm=0 at cycle 3; SDRAM model holds DEADBEEF.
- Read back the same address → READ at cycle 3; rvalid for one cycle at cycle 6 with rdata=32'hDEADBEEF.
- Write wmask=4'b0101, wdata=32'h11223344 over DEADBEEF → dm=4'b1010 in the WRITE cycle; read returns 32'hDE22BE44.
- req held high across a refresh tick → REF issued before ACT, ready low until REF + T_RC; the request is then served with correct data; refreshes stay spaced ≤ REF_INTERVAL + access length.
- rst asserted 1 cycle after a read's READ command → no rvalid, outputs at reset values next cycle, full init sequence repeats; a subsequent read returns the previously written data.

Source files
------------

// File: rtl/sdram_ctrl.sv
// Single-port controller for a 2M x 32 SDRAM (4 banks x 2048 rows x 256 columns):
// power-up init, periodic auto-refresh, single-word reads/writes with auto-precharge.
module sdram_ctrl #(
   parameter int INIT_WAIT    = 20000,
   parameter int REF_INTERVAL = 780,
   parameter int T_RP         = 2,
   parameter int T_RC         = 7,
   parameter int T_RCD        = 2,
   parameter int T_WR         = 2,
   parameter int CL           = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [20:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        sd_cke,
   output logic        sd_cs_n,
   output logic        sd_ras_n,
   output logic        sd_cas_n,
   output logic        sd_we_n,
   output logic [1:0]  sd_ba,
   output logic [10:0] sd_addr,
   output logic [3:0]  sd_dm,
   output logic [31:0] sd_dq_o,
   output logic        sd_dq_oe,
   input  logic [31:0] sd_dq_i
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   localparam logic [10:0] MRS_VAL = (CL == 3) ? 11'h030 : 11'h020;

   // Access length measured from the ACT cycle; both tails must also respect tRC.
   localparam int RD_TAIL = (CL + 1 > T_RP) ? CL + 1 : T_RP;
   localparam int RD_END  = (T_RCD + RD_TAIL > T_RC) ? T_RCD + RD_TAIL : T_RC;
   localparam int WR_END  = (T_RCD + T_WR + T_RP > T_RC) ? T_RCD + T_WR + T_RP : T_RC;

   localparam int CW  = $clog2(INIT_WAIT + T_RC + 32);
   localparam int RCW = $clog2(REF_INTERVAL + 1);

   typedef enum logic [3:0] {
      S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
      S_IDLE, S_REF, S_ACT, S_ACC
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RCW-1:0]  ref_cnt_q, ref_cnt_d;
   logic            ref_run_q, ref_run_d;
   logic            ref_pending_q, ref_pending_d;
   logic            ref_running, ref_tick;
   logic            we_q, we_d;
   logic [20:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      wmask_q, wmask_d;
   logic [3:0]      cmd_q, cmd_d;
   logic [1:0]      ba_q, ba_d;
   logic [10:0]     sd_addr_q, sd_addr_d;
   logic [3:0]      dm_q, dm_d;
   logic [31:0]     dq_o_q, dq_o_d;
   logic            dq_oe_q, dq_oe_d;
   logic            ready_q, ready_d;
   logic            rvalid_q, rvalid_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [CL:0]     rd_vld_q, rd_vld_d;
   logic            issue_rd;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      cmd_d      = CMD_NOP;
      ba_d       = '0;
      sd_addr_d  = '0;
      dm_d       = '1;
      dq_o_d     = '0;
      dq_oe_d    = 1'b0;
      issue_rd   = 1'b0;

      // Refresh timer free-runs once IDLE has been reached the first time.
      ref_running   = ref_run_q | (state_q == S_IDLE);
      ref_run_d     = ref_running;
      ref_tick      = ref_running && (ref_cnt_q == RCW'(REF_INTERVAL - 1));
      ref_cnt_d     = (!ref_running || ref_tick) ? '0 : ref_cnt_q + 1'b1;
      ref_pending_d = ref_pending_q | ref_tick;

      case (state_q)
         S_INIT_WAIT: if (cnt_q == CW'(INIT_WAIT - 1)) begin
            cmd_d     = CMD_PRE;
            sd_addr_d = 11'h400;
            state_d   = S_INIT_PRE;
            cnt_d     = '0;
         end
         S_INIT_PRE: if (cnt_q == CW'(T_RP - 1)) begin
            cmd_d   = CMD_REF;
            state_d = S_INIT_REF1;
            cnt_d   = '0;
         end
         S_INIT_REF1: if (cnt_q == CW'(T_RC - 1)) begin
            cmd_d   = CMD_REF;
            state_d = S_INIT_REF2;
            cnt_d   = '0;
         end
         S_INIT_REF2: if (cnt_q == CW'(T_RC - 1)) begin
            cmd_d     = CMD_MRS;
            sd_addr_d = MRS_VAL;
            state_d   = S_INIT_MRS;
            cnt_d     = '0;
         end
         S_INIT_MRS: if (cnt_q == CW'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         S_IDLE: begin
            cnt_d = '0;
            if (ref_pending_q) begin
               cmd_d         = CMD_REF;
               ref_pending_d = ref_tick;
               state_d       = S_REF;
            end else if (req && ready_q) begin
               we_d      = we;
               addr_d    = addr;
               wdata_d   = wdata;
               wmask_d   = wmask;
               cmd_d     = CMD_ACT;
               ba_d      = addr[20:19];
               sd_addr_d = addr[18:8];
               state_d   = S_ACT;
            end
         end
         S_REF: if (cnt_q == CW'(T_RC - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         S_ACT: if (cnt_q == CW'(T_RCD - 1)) begin
            cmd_d     = we_q ? CMD_WR : CMD_RD;
            ba_d      = addr_q[20:19];
            sd_addr_d = {1'b1, 2'b00, addr_q[7:0]};
            issue_rd  = !we_q;
            if (we_q) begin
               dq_o_d  = wdata_q;
               dq_oe_d = 1'b1;
               dm_d    = ~wmask_q;
            end
            state_d = S_ACC;
         end
         S_ACC: if (cnt_q == (we_q ? CW'(WR_END - 1) : CW'(RD_END - 1))) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_INIT_WAIT;
            cnt_d   = '0;
         end
      endcase

      // Read data returns CL cycles after the READ; capture it and pulse rvalid.
      rd_vld_d = {rd_vld_q[CL-1:0], issue_rd};
      rvalid_d = rd_vld_q[CL];
      rdata_d  = rd_vld_q[CL] ? sd_dq_i : rdata_q;

      ready_d = (state_d == S_IDLE) && !ref_pending_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_INIT_WAIT;
         cnt_q         <= '0;
         ref_cnt_q     <= '0;
         ref_run_q     <= 1'b0;
         ref_pending_q <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wmask_q       <= '0;
         cmd_q         <= CMD_NOP;
         ba_q          <= '0;
         sd_addr_q     <= '0;
         dm_q          <= '1;
         dq_o_q        <= '0;
         dq_oe_q       <= 1'b0;
         ready_q       <= 1'b0;
         rvalid_q      <= 1'b0;
         rdata_q       <= '0;
         rd_vld_q      <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ref_cnt_q     <= ref_cnt_d;
         ref_run_q     <= ref_run_d;
         ref_pending_q <= ref_pending_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wmask_q       <= wmask_d;
         cmd_q         <= cmd_d;
         ba_q          <= ba_d;
         sd_addr_q     <= sd_addr_d;
         dm_q          <= dm_d;
         dq_o_q        <= dq_o_d;
         dq_oe_q       <= dq_oe_d;
         ready_q       <= ready_d;
         rvalid_q      <= rvalid_d;
         rdata_q       <= rdata_d;
         rd_vld_q      <= rd_vld_d;
      end
   end

   assign sd_cke = 1'b1;
   assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
   assign sd_ba    = ba_q;
   assign sd_addr  = sd_addr_q;
   assign sd_dm    = dm_q;
   assign sd_dq_o  = dq_o_q;
   assign sd_dq_oe = dq_oe_q;
   assign ready    = ready_q;
   assign rvalid   = rvalid_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_sdram_ctrl.sv
// Bench for sdram_ctrl: behavioural SDRAM on the pins, with expected commands and
// read responses queued by the stimulus and checked by an independent monitor.
module tb_sdram_ctrl;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_MRS = 4'b0000;

   localparam logic [20:0] A1 = 21'h1A_5F3C;
   localparam logic [20:0] A2 = 21'h0C_0A81;

   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
   logic [20:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wmask = '0;
   logic        ready, rvalid, sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_dq_oe;
   logic [31:0] rdata, sd_dq_o;
   logic [1:0]  sd_ba;
   logic [10:0] sd_addr;
   logic [3:0]  sd_dm;
   logic [31:0] sd_dq_i = '0;

   sdram_ctrl #(.INIT_WAIT(100), .REF_INTERVAL(200)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wmask(wmask),
      .ready(ready), .rvalid(rvalid), .rdata(rdata), .sd_cke(sd_cke), .sd_cs_n(sd_cs_n),
      .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n), .sd_ba(sd_ba),
      .sd_addr(sd_addr), .sd_dm(sd_dm), .sd_dq_o(sd_dq_o), .sd_dq_oe(sd_dq_oe), .sd_dq_i(sd_dq_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [10:0] a;
      logic        oe;
      logic [3:0]  dm;
      logic [31:0] dq;
   } cmd_t;
   typedef struct {
      int          c;
      logic [31:0] d;
   } rsp_t;

   cmd_t cq[$];
   rsp_t rq[$];
   int n_chk = 0, n_fail = 0;
   int last_ref = 0;

   function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endfunction

   function automatic void chk_le(string name, int got, int lim);
      n_chk++;
      if (got > lim) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0d expected <= %0d", name, cyc, got, lim);
      end
   endfunction

   // Behavioural SDRAM and monitor
   logic [31:0] mem [int];
   logic [10:0] open_row [4];
   int          rd_due = -1;
   logic [31:0] rd_word = '0;
   logic [3:0]  mcmd;
   int          mkey;
   logic [31:0] mword;
   cmd_t        me;
   rsp_t        mr;

   always @(negedge clk) begin
      sd_dq_i = (cyc == rd_due) ? rd_word : 32'h0;
      if (cyc > 0 && !rst) begin
         mcmd = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};
         if (mcmd == C_ACT) open_row[sd_ba] = sd_addr;
         if (mcmd == C_WR || mcmd == C_RD) begin
            mkey  = int'({sd_ba, open_row[sd_ba], sd_addr[7:0]});
            mword = mem.exists(mkey) ? mem[mkey] : 32'h0;
            if (mcmd == C_WR) begin
               for (int b = 0; b < 4; b++)
                  if (!sd_dm[b]) mword[8*b +: 8] = sd_dq_o[8*b +: 8];
               mem[mkey] = mword;
            end else begin
               rd_due  = cyc + 2;
               rd_word = mword;
            end
         end
         if (mcmd !== C_NOP) begin
            if (mcmd == C_REF && (cq.size() == 0 || cq[0].cmd != C_REF)) begin
               chk_le("refresh_spacing", cyc - last_ref, 220);
               last_ref = cyc;
            end else if (cq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_cmd @cycle %0d: got %b expected none", cyc, mcmd);
            end else begin
               me = cq.pop_front();
               chk("cmd_code", 128'(mcmd), 128'(me.cmd));
               chk("cmd_cycle", 128'(cyc), 128'(me.c));
               chk("cmd_ba", 128'(sd_ba), 128'(me.ba));
               chk("cmd_addr", 128'(sd_addr), 128'(me.a));
               chk("cmd_oe_dm", 128'({sd_dq_oe, sd_dm}), 128'({me.oe, me.dm}));
               if (me.oe) chk("cmd_dq", 128'(sd_dq_o), 128'(me.dq));
               if (mcmd == C_REF) last_ref = cyc;
            end
         end
         if (rvalid) begin
            if (rq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_rvalid @cycle %0d: got rdata %0h expected no response", cyc, rdata);
            end else begin
               mr = rq.pop_front();
               chk("rvalid_cycle", 128'(cyc), 128'(mr.c));
               chk("rdata", 128'(rdata), 128'(mr.d));
            end
         end
      end
   end

   task automatic push_cmd(input int c, input logic [3:0] cmd, input logic [1:0] ba,
                           input logic [10:0] a, input logic oe, input logic [3:0] dm,
                           input logic [31:0] dq);
      cmd_t e;
      e.c = c; e.cmd = cmd; e.ba = ba; e.a = a; e.oe = oe; e.dm = dm; e.dq = dq;
      cq.push_back(e);
   endtask

   task automatic wait_ready(output int c, input int limit);
      c = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (ready) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL ready_timeout @cycle %0d: got no ready expected ready within %0d cycles", cyc, limit);
      end
   endtask

   // ACT one cycle after accept, READ/WRITE two later, read data three after that.
   task automatic expect_access(input int c, input logic w, input logic [20:0] a,
                                input logic [31:0] d, input logic [3:0] dm_exp,
                                input logic [31:0] exp_rd, input logic exp_rv);
      rsp_t r;
      push_cmd(c + 1, C_ACT, a[20:19], a[18:8], 1'b0, 4'hF, 32'h0);
      push_cmd(c + 3, w ? C_WR : C_RD, a[20:19], {1'b1, 2'b00, a[7:0]}, w, dm_exp, d);
      if (!w && exp_rv) begin
         r.c = c + 6;
         r.d = exp_rd;
         rq.push_back(r);
      end
   endtask

   task automatic access(input logic w, input logic [20:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [3:0] dm_exp,
                         input logic [31:0] exp_rd, input logic exp_rv, output int c);
      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; wdata = d; wmask = m;
      wait_ready(c, 100);
      if (c >= 0) expect_access(c, w, a, d, dm_exp, exp_rd, exp_rv);
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic init_expect(input int r0);
      int c;
      push_cmd(r0 + 100, C_PRE, 2'd0, 11'h400, 1'b0, 4'hF, 32'h0);
      push_cmd(r0 + 102, C_REF, 2'd0, 11'h000, 1'b0, 4'hF, 32'h0);
      push_cmd(r0 + 109, C_REF, 2'd0, 11'h000, 1'b0, 4'hF, 32'h0);
      push_cmd(r0 + 116, C_MRS, 2'd0, 11'h020, 1'b0, 4'hF, 32'h0);
      wait_ready(c, 300);
      chk("ready_after_mrs", 128'(c), 128'(r0 + 118));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog @cycle %0d: got no finish expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, r1, c;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      r0 = cyc;
      @(negedge clk);
      chk("reset_pins", 128'({sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_ba, sd_addr, sd_dm, sd_dq_oe}),
          128'({1'b1, 4'b0111, 2'd0, 11'h0, 4'hF, 1'b0}));
      chk("reset_bus", 128'({ready, rvalid, rdata, sd_dq_o}), 128'(0));
      init_expect(r0);

      access(1'b1, A1, 32'hDEADBEEF, 4'hF,    4'h0,    32'h0,        1'b0, c);
      access(1'b0, A1, 32'h0,        4'h0,    4'hF,    32'hDEADBEEF, 1'b1, c);
      access(1'b1, A1, 32'h11223344, 4'b0101, 4'b1010, 32'h0,        1'b0, c);
      access(1'b0, A1, 32'h0,        4'h0,    4'hF,    32'hDE22BE44, 1'b1, c);
      access(1'b1, A2, 32'hCAFEF00D, 4'hF,    4'h0,    32'h0,        1'b0, c);

      // Request raised in the cycle the refresh tick lands: REF first, then ACT.
      while (cyc < r0 + 318) begin
         @(posedge clk); #1;
      end
      push_cmd(r0 + 319, C_REF, 2'd0, 11'h000, 1'b0, 4'hF, 32'h0);
      req = 1'b1; we = 1'b0; addr = A2;
      wait_ready(c, 50);
      chk("ready_after_ref", 128'(c), 128'(r0 + 326));
      if (c >= 0) expect_access(c, 1'b0, A2, 32'h0, 4'hF, 32'hCAFEF00D, 1'b1);
      @(posedge clk); #1;
      req = 1'b0;

      // Reset one cycle after a READ: no response, outputs at reset values, re-init.
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; addr = A1;
      wait_ready(c, 50);
      if (c >= 0) expect_access(c, 1'b0, A1, 32'h0, 4'hF, 32'h0, 1'b0);
      @(posedge clk); #1;
      req = 1'b0;
      while (cyc < c + 4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      r1 = cyc;
      @(negedge clk);
      chk("abort_pins", 128'({sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_ba, sd_addr, sd_dm, sd_dq_oe}),
          128'({1'b1, 4'b0111, 2'd0, 11'h0, 4'hF, 1'b0}));
      chk("abort_bus", 128'({ready, rvalid, rdata, sd_dq_o}), 128'(0));
      init_expect(r1);

      access(1'b0, A1, 32'h0, 4'h0, 4'hF, 32'hDE22BE44, 1'b1, c);
      access(1'b0, A2, 32'h0, 4'h0, 4'hF, 32'hCAFEF00D, 1'b1, c);

      // Idle long enough for two autonomous refreshes.
      repeat (450) @(posedge clk);
      #1;
      chk_le("refresh_recent", cyc - last_ref, 220);
      chk("cmd_queue_drained", 128'(cq.size()), 128'(0));
      chk("rsp_queue_drained", 128'(rq.size()), 128'(0));

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
